imm_ext_stage: RTL

Registered, multi-lane immediate extraction and sign-extension stage for the pipelined core, placed between decode and execute. Each lane takes instruction bits [31:7] and a 3-bit format code, produces an XLEN-wide extended immediate, and flags illegal format codes. A valid/ready handshake with a 2-entry skid buffer lets execute stall without a combinational ready path back to decode.

---
 rtl/imm_ext_stage.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/imm_ext_stage.sv
`default_nettype none
// ============================================================================
// Module   : imm_ext_stage
// Purpose  : Registered multi-lane immediate extraction / sign-extension stage
//            with valid/ready handshake and a 1-entry skid register.
//            Optional macro IMM_EXT_ZIMM_EN enables the CSR ZIMM format (op 6).
// Revision : 1.0 - initial release
// ============================================================================
module imm_ext_stage #(
  parameter int XLEN  = 32,
  parameter int LANES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [LANES*25-1:0]   inst_i,
  input  logic [LANES*3-1:0]    sext_op_i,
  input  logic [LANES-1:0]      lane_en_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [LANES*XLEN-1:0] ext_o,
  output logic [LANES-1:0]      lane_en_o,
  output logic [LANES-1:0]      err_o
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  logic [LANES*XLEN-1:0] ext_in;
  logic [LANES-1:0]      err_in;

  // Per-lane extension computed at the input so the registers hold final values
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [24:0]     ins;
    logic [2:0]      op;
    logic [XLEN-1:0] ext;
    logic            err;

    assign ins = inst_i[25*k +: 25];
    assign op  = sext_op_i[3*k +: 3];

    // Decode the format code into the extended immediate and illegal flag
    always_comb begin
      ext = '0;
      err = 1'b0;
      if (lane_en_i[k]) begin
        case (op)
          3'd0: ext = XLEN'($signed(ins[24:13]));
          3'd1: ext = XLEN'($signed({ins[24:18], ins[4:0]}));
          3'd2: ext = XLEN'($signed({ins[24], ins[0], ins[23:18], ins[4:1], 1'b0}));
          3'd3: ext = XLEN'($signed({ins[24:5], 12'b0}));
          3'd4: ext = XLEN'($signed({ins[24], ins[12:5], ins[13], ins[23:14], 1'b0}));
          3'd5: ext = (XLEN == 64) ? XLEN'(ins[18:13]) : XLEN'(ins[17:13]);
`ifdef IMM_EXT_ZIMM_EN
          3'd6: ext = XLEN'(ins[12:8]);
`else
          3'd6: err = 1'b1;
`endif
          default: err = 1'b1;
        endcase
      end
    end

    assign ext_in[k*XLEN +: XLEN] = ext;
    assign err_in[k]              = err;
  end

  state_e                state_q, state_d;
  logic                  ready_q, ready_d;
  logic [LANES*XLEN-1:0] out_ext_q, out_ext_d, skd_ext_q, skd_ext_d;
  logic [LANES-1:0]      out_en_q, out_en_d, skd_en_q, skd_en_d;
  logic [LANES-1:0]      out_err_q, out_err_d, skd_err_q, skd_err_d;
  logic                  accept, drain;

  assign out_valid_o = (state_q != ST_EMPTY);
  assign in_ready_o  = ready_q;
  assign ext_o       = out_ext_q;
  assign lane_en_o   = out_en_q;
  assign err_o       = out_err_q;

  assign accept = in_valid_i & ready_q;
  assign drain  = out_valid_o & out_ready_i;

  // Next-state and data-path steering for the output/skid registers
  always_comb begin
    state_d   = state_q;
    out_ext_d = out_ext_q;
    out_en_d  = out_en_q;
    out_err_d = out_err_q;
    skd_ext_d = skd_ext_q;
    skd_en_d  = skd_en_q;
    skd_err_d = skd_err_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d   = ST_ONE;
          out_ext_d = ext_in;
          out_en_d  = lane_en_i;
          out_err_d = err_in;
        end
      end
      ST_ONE: begin
        if (accept && drain) begin
          out_ext_d = ext_in;
          out_en_d  = lane_en_i;
          out_err_d = err_in;
        end else if (accept) begin
          state_d   = ST_FULL;
          skd_ext_d = ext_in;
          skd_en_d  = lane_en_i;
          skd_err_d = err_in;
        end else if (drain) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (drain) begin
          state_d   = ST_ONE;
          out_ext_d = skd_ext_q;
          out_en_d  = skd_en_q;
          out_err_d = skd_err_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Flush wins over any accept; a concurrent drain has already been seen downstream
    if (flush_i) state_d = ST_EMPTY;
    ready_d = (state_d != ST_FULL);
  end

  // State, ready flop and beat storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_EMPTY;
      ready_q   <= 1'b1;
      out_ext_q <= '0;
      out_en_q  <= '0;
      out_err_q <= '0;
      skd_ext_q <= '0;
      skd_en_q  <= '0;
      skd_err_q <= '0;
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      out_ext_q <= out_ext_d;
      out_en_q  <= out_en_d;
      out_err_q <= out_err_d;
      skd_ext_q <= skd_ext_d;
      skd_en_q  <= skd_en_d;
      skd_err_q <= skd_err_d;
    end
  end

endmodule
`default_nettype wire
